// File: rtl/rca_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
//   NIB_W      : width of the shared adder slice (one nibble)
//   state_t    : sequencer FSM encoding; 2'd3 is unused and recovers to IDLE
//   nib_count  : number of adder passes needed for a given operand width
package rca_ctrl_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nib_count(input int width);
        return width / NIB_W;
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// Purely combinational 4-bit ripple-carry adder.
//   a, b  : nibble operands
//   cin   : carry in
//   sum   : a + b + cin, low 4 bits
//   cout  : carry out of bit 3
module ripple_carry_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fa
            assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[4];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Runs WIDTH-bit add/subtract operations through one shared 4-bit ripple-carry
// adder, one nibble per clock, LSB nibble first. The carry is held in a
// register between passes.
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    : operand request handshake
//   in_a, in_b, in_sub   : operands; in_sub=1 selects A-B
//   out_valid/out_ready  : result handshake
//   out_sum              : A+B or A-B modulo 2^WIDTH
//   out_cout             : add: carry out; sub: 1 = no borrow
//   out_ovf              : two's-complement signed overflow
//   busy                 : high while an operation is running or waiting to be taken
module nibble_serial_add_ctrl
    import rca_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    localparam int NIBBLES = nib_count(WIDTH);
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t state_reg, state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] bx_reg;      // B, or ~B for subtraction
    logic [WIDTH-1:0] sum_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             carry_reg;
    logic             cout_reg;
    logic             ovf_reg;

    logic [NIB_W-1:0] rca_a;
    logic [NIB_W-1:0] rca_b;
    logic [NIB_W-1:0] rca_sum;
    logic             rca_cin;
    logic             rca_cout;

    logic accept;
    logic last_nib;

    assign accept   = (state_reg == IDLE) && in_valid;
    assign last_nib = (idx_reg == LAST_IDX);

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        rca_a      = '0;
        rca_b      = '0;
        rca_cin    = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                rca_a   = a_reg[NIB_W*idx_reg +: NIB_W];
                rca_b   = bx_reg[NIB_W*idx_reg +: NIB_W];
                rca_cin = carry_reg;
                if (last_nib) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            bx_reg    <= '0;
            sum_reg   <= '0;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
            a_reg     <= in_a;
            bx_reg    <= in_sub ? ~in_b : in_b;
            carry_reg <= in_sub;
            idx_reg   <= '0;
        end else if (state_reg == RUN) begin
            sum_reg[NIB_W*idx_reg +: NIB_W] <= rca_sum;
            carry_reg <= rca_cout;
            idx_reg   <= idx_reg + IDX_W'(1);
            if (last_nib) begin
                cout_reg <= rca_cout;
                // Overflow: operands (after B inversion) share a sign that the result lacks.
                ovf_reg  <= (a_reg[WIDTH-1] == bx_reg[WIDTH-1]) &&
                            (rca_sum[NIB_W-1] != a_reg[WIDTH-1]);
            end
        end
    end

    ripple_carry_adder u_rca (
        .a    (rca_a),
        .b    (rca_b),
        .cin  (rca_cin),
        .sum  (rca_sum),
        .cout (rca_cout)
    );

    assign out_sum  = sum_reg;
    assign out_cout = cout_reg;
    assign out_ovf  = ovf_reg;

endmodule
